// File: rtl/fetch_pkg.sv
// Shared types and sizes for the fetch sequencer and the fetch datapath.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fetch_ctrl_state_t;

  localparam int WIN_ROWS = 32;
  localparam int WROW_W   = $clog2(WIN_ROWS);

  localparam int DEF_ROI_DEPTH = 6;
  localparam int DEF_ROI_WIDTH = 6;
  localparam int DEF_POI_DEPTH = 4;
  localparam int DEF_POI_WIDTH = 4;

  localparam int W_ADDR_W   = DEF_ROI_DEPTH + DEF_ROI_WIDTH;
  localparam int POI_ADDR_W = DEF_POI_DEPTH + DEF_POI_WIDTH;

endpackage

// File: rtl/fetch_ctrl_addr_gen.sv
// Combinational address generation: clamped window column, vertically
// wrapping window row and wrapping POI index.
module fetch_ctrl_addr_gen
  import fetch_pkg::*;
#(
  parameter int ROI_DEPTH = DEF_ROI_DEPTH,
  parameter int ROI_WIDTH = DEF_ROI_WIDTH,
  parameter int POI_DEPTH = DEF_POI_DEPTH,
  parameter int POI_WIDTH = DEF_POI_WIDTH
) (
  input  logic [ROI_WIDTH-1:0]           win_x_i,
  input  logic [ROI_DEPTH-1:0]           win_y_i,
  input  logic [WROW_W-1:0]              r_i,
  input  logic [POI_DEPTH+POI_WIDTH-1:0] poi_first_i,
  input  logic [POI_DEPTH+POI_WIDTH-1:0] k_i,
  output logic [ROI_DEPTH+ROI_WIDTH-1:0] w_addr_o,
  output logic [POI_DEPTH+POI_WIDTH-1:0] poi_addr_o
);

  // Rightmost column origin that still keeps a full window row inside one ROI row.
  localparam logic [ROI_WIDTH-1:0] X_MAX = ROI_WIDTH'((1 << ROI_WIDTH) - WIN_ROWS);

  logic [ROI_WIDTH-1:0] x_clamped;
  logic [ROI_DEPTH-1:0] y_row;

  always_comb begin
    x_clamped  = (win_x_i > X_MAX) ? X_MAX : win_x_i;
    y_row      = win_y_i + ROI_DEPTH'(r_i);
    w_addr_o   = {y_row, x_clamped};
    poi_addr_o = poi_first_i + k_i;
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: walks POIs and issues 32 window-row reads per POI with backpressure.
// Optional FETCH_CTRL_PERF_EN adds saturating stall/row performance counters.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int ROI_DEPTH = DEF_ROI_DEPTH,
  parameter int ROI_WIDTH = DEF_ROI_WIDTH,
  parameter int POI_DEPTH = DEF_POI_DEPTH,
  parameter int POI_WIDTH = DEF_POI_WIDTH
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [ROI_WIDTH-1:0]             win_x,
  input  logic [ROI_DEPTH-1:0]             win_y,
  input  logic [POI_DEPTH+POI_WIDTH-1:0]   poi_first,
  input  logic [POI_DEPTH+POI_WIDTH:0]     poi_count,
  input  logic                             ready,
  output logic                             fetch_en,
  output logic [ROI_DEPTH+ROI_WIDTH-1:0]   w_addr_re,
  output logic [POI_DEPTH+POI_WIDTH-1:0]   POI_addr_re,
  output logic [4:0]                       w_row,
  output logic                             data_valid,
  output logic                             data_last,
  output logic                             busy,
  output logic                             done
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [15:0]                      stall_cnt,
  output logic [15:0]                      row_cnt
`endif
);

  localparam int AW = ROI_DEPTH + ROI_WIDTH;
  localparam int PW = POI_DEPTH + POI_WIDTH;
  localparam int CW = PW + 1;
  localparam logic [WROW_W-1:0] R_LAST = WROW_W'(WIN_ROWS - 1);

  fetch_ctrl_state_t state_q, state_d;
  logic [WROW_W-1:0]    r_q, r_d;
  logic [PW-1:0]        k_q, k_d;
  logic [ROI_WIDTH-1:0] win_x_q, win_x_d;
  logic [ROI_DEPTH-1:0] win_y_q, win_y_d;
  logic [PW-1:0]        poi_first_q, poi_first_d;
  logic [CW-1:0]        poi_count_q, poi_count_d;
  logic                 dv_q, dv_d;
  logic                 dl_q, dl_d;
  logic                 is_final;
  logic                 start_accept;

  logic [AW-1:0] gen_w_addr;
  logic [PW-1:0] gen_poi_addr;

  fetch_ctrl_addr_gen #(
    .ROI_DEPTH (ROI_DEPTH),
    .ROI_WIDTH (ROI_WIDTH),
    .POI_DEPTH (POI_DEPTH),
    .POI_WIDTH (POI_WIDTH)
  ) u_addr_gen (
    .win_x_i     (win_x_q),
    .win_y_i     (win_y_q),
    .r_i         (r_q),
    .poi_first_i (poi_first_q),
    .k_i         (k_q),
    .w_addr_o    (gen_w_addr),
    .poi_addr_o  (gen_poi_addr)
  );

  always_comb begin
    state_d      = state_q;
    r_d          = r_q;
    k_d          = k_q;
    win_x_d      = win_x_q;
    win_y_d      = win_y_q;
    poi_first_d  = poi_first_q;
    poi_count_d  = poi_count_q;
    dv_d         = 1'b0;
    dl_d         = 1'b0;
    fetch_en     = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    start_accept = 1'b0;
    is_final     = (r_q == R_LAST) && ({1'b0, k_q} == (poi_count_q - CW'(1)));

    case (state_q)
      IDLE: begin
        if (start) begin
          start_accept = 1'b1;
          win_x_d      = win_x;
          win_y_d      = win_y;
          poi_first_d  = poi_first;
          poi_count_d  = poi_count;
          r_d          = '0;
          k_d          = '0;
          state_d      = (poi_count == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        busy     = 1'b1;
        fetch_en = ready;
        if (ready) begin
          dv_d = 1'b1;
          dl_d = is_final;
          if (r_q == R_LAST) begin
            r_d = '0;
            k_d = k_q + PW'(1);
            if (is_final) begin
              state_d = DRAIN;
            end
          end else begin
            r_d = r_q + WROW_W'(1);
          end
        end
      end
      DRAIN: begin
        // Last row's data_valid lands here, one cycle after its fetch_en.
        busy    = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      r_q         <= '0;
      k_q         <= '0;
      win_x_q     <= '0;
      win_y_q     <= '0;
      poi_first_q <= '0;
      poi_count_q <= '0;
      dv_q        <= 1'b0;
      dl_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      k_q         <= k_d;
      win_x_q     <= win_x_d;
      win_y_q     <= win_y_d;
      poi_first_q <= poi_first_d;
      poi_count_q <= poi_count_d;
      dv_q        <= dv_d;
      dl_q        <= dl_d;
    end
  end

  // Addresses are only meaningful while reading; elsewhere they read as zero.
  assign w_addr_re   = (state_q == RUN) ? gen_w_addr : '0;
  assign POI_addr_re = (state_q == RUN) ? gen_poi_addr : '0;
  assign w_row       = (state_q == RUN) ? 5'(r_q) : 5'd0;
  assign data_valid  = dv_q;
  assign data_last   = dl_q;

`ifdef FETCH_CTRL_PERF_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] row_cnt_q, row_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    row_cnt_d   = row_cnt_q;
    if (start_accept) begin
      stall_cnt_d = '0;
      row_cnt_d   = '0;
    end else begin
      if ((state_q == RUN) && !ready && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_d = stall_cnt_q + 16'd1;
      end
      if (fetch_en && (row_cnt_q != 16'hFFFF)) begin
        row_cnt_d = row_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      row_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      row_cnt_q   <= row_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign row_cnt   = row_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl against a row-list reference model.
`timescale 1ns/1ps
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        ready;
  logic [5:0]  win_x;
  logic [5:0]  win_y;
  logic [7:0]  poi_first;
  logic [8:0]  poi_count;
  logic        fetch_en;
  logic [11:0] w_addr_re;
  logic [7:0]  POI_addr_re;
  logic [4:0]  w_row;
  logic        data_valid;
  logic        data_last;
  logic        busy;
  logic        done;
`ifdef FETCH_CTRL_PERF_EN
  logic [15:0] stall_cnt;
  logic [15:0] row_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .win_x       (win_x),
    .win_y       (win_y),
    .poi_first   (poi_first),
    .poi_count   (poi_count),
    .ready       (ready),
    .fetch_en    (fetch_en),
    .w_addr_re   (w_addr_re),
    .POI_addr_re (POI_addr_re),
    .w_row       (w_row),
    .data_valid  (data_valid),
    .data_last   (data_last),
    .busy        (busy),
    .done        (done)
`ifdef FETCH_CTRL_PERF_EN
    ,
    .stall_cnt   (stall_cnt),
    .row_cnt     (row_cnt)
`endif
  );

  // Reference: row i of a job reads window row i%32 of POI i/32.
  function automatic int model_addr(int wx, int wy, int i);
    int x;
    x = (wx > 32) ? 32 : wx;
    return (((wy + (i % 32)) % 64) * 64) + x;
  endfunction

  function automatic int model_poi(int pf, int i);
    return (pf + (i / 32)) % 256;
  endfunction

  // mode 0: ready always high; 1: random ready; 2: ready low stall_len cycles at row stall_at
  task automatic run_job(input string name, input int wx, input int wy, input int pf,
                         input int pc, input int mode, input int stall_at,
                         input int stall_len, input bit inject);
    int total, issued, cyc, drain_cyc, done_cyc, stall_done;
    int obs_fe, obs_last, obs_done, exp_stall;
    bit exp_fe, exp_busy, exp_done, prev_fe, prev_final;
    total = 32 * pc;
    issued = 0; drain_cyc = -1; done_cyc = (pc == 0) ? 1 : -1;
    stall_done = 0; obs_fe = 0; obs_last = 0; obs_done = 0; exp_stall = 0;
    prev_fe = 1'b0; prev_final = 1'b0;

    @(negedge clk);
    start = 1'b1; win_x = 6'(wx); win_y = 6'(wy); poi_first = 8'(pf); poi_count = 9'(pc);
    ready = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || fetch_en !== 1'b0)
      $display("FAIL %s idle_before_start busy=%b fetch_en=%b required 0/0", name, busy, fetch_en);
    if (busy !== 1'b0 || fetch_en !== 1'b0) errors++;

    cyc = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      start = inject && (cyc == 5);
      if (inject && cyc == 5) begin
        win_x = 6'(wx ^ 13); win_y = 6'(wy + 7); poi_first = 8'(pf + 3);
      end
      case (mode)
        1: ready = ($urandom_range(0, 3) != 0);
        2: begin
          if (issued == stall_at && stall_done < stall_len) begin
            ready = 1'b0; stall_done++;
          end else ready = 1'b1;
        end
        default: ready = 1'b1;
      endcase
      #1;
      exp_fe   = (issued < total) && ready;
      exp_busy = (issued < total) || (cyc == drain_cyc);
      exp_done = (cyc == done_cyc);

      checks++;
      if (fetch_en !== exp_fe) begin
        errors++;
        $display("FAIL %s fetch_en cyc=%0d got=%b required=%b", name, cyc, fetch_en, exp_fe);
      end
      checks++;
      if (busy !== exp_busy) begin
        errors++;
        $display("FAIL %s busy cyc=%0d got=%b required=%b", name, cyc, busy, exp_busy);
      end
      checks++;
      if (done !== exp_done) begin
        errors++;
        $display("FAIL %s done cyc=%0d got=%b required=%b", name, cyc, done, exp_done);
      end
      checks++;
      if (data_valid !== prev_fe) begin
        errors++;
        $display("FAIL %s data_valid cyc=%0d got=%b required=%b", name, cyc, data_valid, prev_fe);
      end
      checks++;
      if (data_last !== (prev_fe && prev_final)) begin
        errors++;
        $display("FAIL %s data_last cyc=%0d got=%b required=%b", name, cyc, data_last,
                 prev_fe && prev_final);
      end
      if (issued < total) begin
        checks++;
        if (w_addr_re !== 12'(model_addr(wx, wy, issued)) ||
            POI_addr_re !== 8'(model_poi(pf, issued)) ||
            w_row !== 5'(issued % 32)) begin
          errors++;
          $display("FAIL %s addr row=%0d got w_addr=%0d poi=%0d w_row=%0d required %0d/%0d/%0d",
                   name, issued, w_addr_re, POI_addr_re, w_row, model_addr(wx, wy, issued),
                   model_poi(pf, issued), issued % 32);
        end
        if (!ready) exp_stall++;
      end

      if (fetch_en === 1'b1) obs_fe++;
      if (data_last === 1'b1) obs_last++;
      if (done === 1'b1) obs_done++;

      if (exp_fe) begin
        prev_final = (issued == total - 1);
        issued++;
        if (issued == total) begin
          drain_cyc = cyc + 1;
          done_cyc  = cyc + 2;
        end
      end else begin
        prev_final = 1'b0;
      end
      prev_fe = exp_fe;

      if (done_cyc > 0 && cyc > done_cyc) break;
      if (cyc > 4000) begin
        checks++; errors++;
        $display("FAIL %s timeout cyc=%0d issued=%0d required=%0d", name, cyc, issued, total);
        break;
      end
    end

    checks++;
    if (obs_fe != total || obs_done != 1 || obs_last != ((total > 0) ? 1 : 0)) begin
      errors++;
      $display("FAIL %s totals fetch_en=%0d done=%0d last=%0d required %0d/1/%0d",
               name, obs_fe, obs_done, obs_last, total, (total > 0) ? 1 : 0);
    end
`ifdef FETCH_CTRL_PERF_EN
    checks++;
    if (stall_cnt !== 16'(exp_stall) || row_cnt !== 16'(total)) begin
      errors++;
      $display("FAIL %s perf stall_cnt=%0d row_cnt=%0d required %0d/%0d",
               name, stall_cnt, row_cnt, exp_stall, total);
    end
`endif
    $display("job %s: win_x=%0d win_y=%0d poi_first=%0d poi_count=%0d rows=%0d stalls=%0d cycles=%0d",
             name, wx, wy, pf, pc, obs_fe, exp_stall, cyc);
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b1; ready = 1'b1;
    win_x = 6'd5; win_y = 6'd5; poi_first = 8'd1; poi_count = 9'd2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({fetch_en, w_addr_re, POI_addr_re, w_row, data_valid, data_last, busy, done} !== 30'd0) begin
        errors++;
        $display("FAIL reset_outputs cyc=%0d got fe=%b addr=%0d poi=%0d row=%0d dv=%b dl=%b busy=%b done=%b required all 0",
                 i, fetch_en, w_addr_re, POI_addr_re, w_row, data_valid, data_last, busy, done);
      end
    end
`ifdef FETCH_CTRL_PERF_EN
    checks++;
    if (stall_cnt !== 16'd0 || row_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_perf stall_cnt=%0d row_cnt=%0d required 0/0", stall_cnt, row_cnt);
    end
`endif
    start = 1'b0;
    reset = 1'b1;
    $display("reset: outputs held at zero with start asserted");
  endtask

  task automatic test_reset_mid_job();
    @(negedge clk);
    start = 1'b1; win_x = 6'd20; win_y = 6'd3; poi_first = 8'd9; poi_count = 9'd4; ready = 1'b1;
    for (int c = 1; c <= 38; c++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
    end
    checks++;
    if (w_row !== 5'd5 || POI_addr_re !== 8'd10 || fetch_en !== 1'b1) begin
      errors++;
      $display("FAIL midjob_position w_row=%0d poi=%0d fe=%b required 5/10/1", w_row, POI_addr_re, fetch_en);
    end
    reset = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if ({fetch_en, w_addr_re, POI_addr_re, w_row, data_valid, data_last, busy, done} !== 30'd0) begin
      errors++;
      $display("FAIL midjob_reset got fe=%b addr=%0d poi=%0d row=%0d dv=%b dl=%b busy=%b done=%b required all 0",
               fetch_en, w_addr_re, POI_addr_re, w_row, data_valid, data_last, busy, done);
    end
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || fetch_en !== 1'b0) begin
        errors++;
        $display("FAIL midjob_after cyc=%0d done=%b busy=%b fe=%b required 0/0/0", c, done, busy, fetch_en);
      end
    end
    $display("reset_mid_job: job abandoned at r=5 k=1");
    run_job("after_reset", 11, 30, 200, 1, 0, 0, 0, 1'b0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; ready = 1'b1;
    win_x = '0; win_y = '0; poi_first = '0; poi_count = '0;
    test_reset();
    run_job("basic", 0, 0, 0, 1, 0, 0, 0, 1'b0);
    run_job("wrap", 50, 40, 255, 2, 0, 0, 0, 1'b0);
    run_job("backpressure", 7, 12, 3, 1, 2, 10, 3, 1'b0);
    run_job("zero_count", 9, 9, 9, 0, 0, 0, 0, 1'b0);
    test_reset_mid_job();
    run_job("start_while_busy", 17, 22, 100, 2, 0, 0, 0, 1'b1);
    run_job("clamp_edge", 33, 63, 254, 3, 1, 0, 0, 1'b0);
    for (int j = 0; j < 4; j++) begin
      run_job("random", int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
              int'($urandom_range(0, 255)), int'($urandom_range(1, 3)), 1, 0, 0,
              ($urandom_range(0, 1) == 1));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
